main: RTL and testbench

MAIN -- requirements
Module: main

---
 rtl/main_pkg.sv | 27 ++
 rtl/main_alu_core.sv | 26 ++
 rtl/main.sv | 86 ++++++++
 tb/tb_main.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/main_pkg.sv
// Shared encodings for the operand-register FSM and the ALU operation select.
package main_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'b00,
      ST_LOAD  = 2'b01,
      ST_HOLD  = 2'b10,
      ST_OFF   = 2'b11
   } state_t;

   localparam int SEL_PERSIST = 2;
   localparam int SEL_LOAD    = 1;
   localparam int SEL_CLEAR   = 0;

   localparam int OP_ADD = 6;
   localparam int OP_SUB = 5;
   localparam int OP_AND = 4;
   localparam int OP_OR  = 3;
   localparam int OP_XOR = 2;
   localparam int OP_NOT = 1;
   localparam int OP_SHL = 0;

   localparam logic [2:0] CMD_PERSIST = 3'b001 << SEL_PERSIST;
   localparam logic [2:0] CMD_LOAD    = 3'b001 << SEL_LOAD;
   localparam logic [2:0] CMD_CLEAR   = 3'b001 << SEL_CLEAR;

endpackage

// File: rtl/main_alu_core.sv
// Combinational 8-bit ALU; any select that is not exactly one-hot yields zero.
module alu_core
   import main_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic [6:0] op,
   output logic [7:0] y
);

   // Operation decode; carries and borrows fall off the 8-bit result.
   always_comb begin
      y = 8'h00;
      case (op)
         7'b0000001 << OP_ADD: y = a + b;
         7'b0000001 << OP_SUB: y = a - b;
         7'b0000001 << OP_AND: y = a & b;
         7'b0000001 << OP_OR:  y = a | b;
         7'b0000001 << OP_XOR: y = a ^ b;
         7'b0000001 << OP_NOT: y = ~a;
         7'b0000001 << OP_SHL: y = a << 1;
         default:              y = 8'h00;
      endcase
   end

endmodule

// File: rtl/main.sv
// Operand-register FSM (clear/load/hold/off) feeding a one-hot selected ALU.
module main
   import main_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       on,
   input  logic [2:0] in_sel,
   input  logic [7:0] num1,
   input  logic [7:0] num2,
   input  logic [6:0] out_sel,
   output logic [7:0] final1,
   output logic [7:0] final2,
   output logic [7:0] out,
   output logic [1:0] currState,
   output logic [1:0] nextState
);

   state_t     state;
   state_t     next_state;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic [7:0] alu_y;

   // Next-state decode; unrecognised or multi-hot commands keep the current state.
   always_comb begin
      next_state = state;
      if (!on) begin
         next_state = ST_OFF;
      end else begin
         case (in_sel)
            CMD_CLEAR:   next_state = ST_CLEAR;
            CMD_LOAD:    next_state = ST_LOAD;
            CMD_PERSIST: next_state = ST_HOLD;
            default:     next_state = state;
         endcase
      end
   end

   // State and operand registers; operands follow the state being entered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_CLEAR;
         op_a  <= 8'h00;
         op_b  <= 8'h00;
      end else begin
         state <= next_state;
         case (next_state)
            ST_LOAD: begin
               op_a <= num1;
               op_b <= num2;
            end
            ST_CLEAR: begin
               op_a <= 8'h00;
               op_b <= 8'h00;
            end
            default: begin
               op_a <= op_a;
               op_b <= op_b;
            end
         endcase
      end
   end

   alu_core u_alu (
      .a  (op_a),
      .b  (op_b),
      .op (out_sel),
      .y  (alu_y)
   );

   // Result is forced to zero when off or cleared (e.g. ~A would otherwise show 0xFF).
   always_comb begin
      if ((state == ST_OFF) || (state == ST_CLEAR)) begin
         out = 8'h00;
      end else begin
         out = alu_y;
      end
   end

   assign final1    = op_a;
   assign final2    = op_b;
   assign currState = state;
   assign nextState = next_state;

endmodule

// File: tb/tb_main.sv
// Scoreboard bench for main: stimulus queues expectations, a monitor samples before and after each edge.
module tb_main;

   logic       clk;
   logic       rst;
   logic       on;
   logic [2:0] in_sel;
   logic [7:0] num1;
   logic [7:0] num2;
   logic [6:0] out_sel;
   logic [7:0] final1;
   logic [7:0] final2;
   logic [7:0] out;
   logic [1:0] currState;
   logic [1:0] nextState;

   typedef struct {
      int         due;
      bit         pre;
      string      tag;
      logic [1:0] cs;
      logic [1:0] ns;
      logic [7:0] f1;
      logic [7:0] f2;
      logic [7:0] o;
   } exp_t;

   exp_t q[$];
   int   neg_cnt = 0;
   int   checks = 0;
   int   failures = 0;

   localparam logic [6:0] ADD = 7'b1000000;
   localparam logic [6:0] SUB = 7'b0100000;
   localparam logic [6:0] AND = 7'b0010000;
   localparam logic [6:0] OR  = 7'b0001000;
   localparam logic [6:0] XOR = 7'b0000100;
   localparam logic [6:0] NOT = 7'b0000010;
   localparam logic [6:0] SHL = 7'b0000001;

   main dut (
      .clk       (clk),
      .rst       (rst),
      .on        (on),
      .in_sel    (in_sel),
      .num1      (num1),
      .num2      (num2),
      .out_sel   (out_sel),
      .final1    (final1),
      .final2    (final2),
      .out       (out),
      .currState (currState),
      .nextState (nextState)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) neg_cnt <= neg_cnt + 1;

   task automatic cmp(input string tag, input string field, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s.%s actual=%h expected=%h", tag, field, act, exp);
      end
   endtask

   // pre_phase=1: sample 3 time units after the falling edge, before the rising edge
   task automatic drain(input bit pre_phase);
      exp_t e;
      while (q.size() > 0 &&
             (q[0].due < neg_cnt || (q[0].due == neg_cnt && (q[0].pre || !pre_phase)))) begin
         e = q.pop_front();
         cmp(e.tag, "currState", {6'b000000, currState}, {6'b000000, e.cs});
         cmp(e.tag, "nextState", {6'b000000, nextState}, {6'b000000, e.ns});
         cmp(e.tag, "final1", final1, e.f1);
         cmp(e.tag, "final2", final2, e.f2);
         cmp(e.tag, "out", out, e.o);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #3;
         drain(1'b1);
         @(posedge clk);
         #2;
         drain(1'b0);
      end
   end

   task automatic expect_vals(input bit pre, input string tag, input logic [1:0] cs, input logic [1:0] ns,
                              input logic [7:0] f1, input logic [7:0] f2, input logic [7:0] o);
      exp_t e;
      e.due = neg_cnt;
      e.pre = pre;
      e.tag = tag;
      e.cs  = cs;
      e.ns  = ns;
      e.f1  = f1;
      e.f2  = f2;
      e.o   = o;
      q.push_back(e);
   endtask

   // Each step starts just after a falling edge; inputs then stay stable through the next rising edge.
   task automatic step(input logic r, input logic en, input logic [2:0] cmd,
                       input logic [7:0] a, input logic [7:0] b, input logic [6:0] os);
      @(negedge clk);
      #1;
      rst     = r;
      on      = en;
      in_sel  = cmd;
      num1    = a;
      num2    = b;
      out_sel = os;
   endtask

   initial begin
      rst = 1'b0; on = 1'b0; in_sel = 3'b000; num1 = 8'h00; num2 = 8'h00; out_sel = 7'b0000000;

      step(1'b0, 1'b0, 3'b000, 8'h00, 8'h00, 7'b0000000);
      expect_vals(1'b1, "rst_pre", 2'b00, 2'b11, 8'h00, 8'h00, 8'h00);
      expect_vals(1'b0, "rst_post", 2'b00, 2'b11, 8'h00, 8'h00, 8'h00);

      step(1'b0, 1'b1, 3'b010, 8'h57, 8'h1A, ADD);
      expect_vals(1'b0, "rst_hold_clk", 2'b00, 2'b01, 8'h00, 8'h00, 8'h00);

      step(1'b1, 1'b1, 3'b010, 8'h57, 8'h1A, ADD);
      expect_vals(1'b1, "release_pre", 2'b00, 2'b01, 8'h00, 8'h00, 8'h00);
      expect_vals(1'b0, "load_57_1a", 2'b01, 2'b01, 8'h57, 8'h1A, 8'h71);

      step(1'b1, 1'b1, 3'b100, 8'h11, 8'h22, ADD);
      expect_vals(1'b0, "hold1", 2'b10, 2'b10, 8'h57, 8'h1A, 8'h71);
      step(1'b1, 1'b1, 3'b100, 8'h33, 8'h44, ADD);
      expect_vals(1'b0, "hold2", 2'b10, 2'b10, 8'h57, 8'h1A, 8'h71);
      step(1'b1, 1'b1, 3'b100, 8'h55, 8'h66, ADD);
      expect_vals(1'b0, "hold3", 2'b10, 2'b10, 8'h57, 8'h1A, 8'h71);

      step(1'b1, 1'b1, 3'b100, 8'h55, 8'h66, SUB);
      expect_vals(1'b1, "sub_comb", 2'b10, 2'b10, 8'h57, 8'h1A, 8'h3D);
      step(1'b1, 1'b1, 3'b100, 8'h55, 8'h66, AND);
      expect_vals(1'b1, "and", 2'b10, 2'b10, 8'h57, 8'h1A, 8'h12);
      step(1'b1, 1'b1, 3'b100, 8'h55, 8'h66, OR);
      expect_vals(1'b1, "or", 2'b10, 2'b10, 8'h57, 8'h1A, 8'h5F);
      step(1'b1, 1'b1, 3'b100, 8'h55, 8'h66, XOR);
      expect_vals(1'b1, "xor", 2'b10, 2'b10, 8'h57, 8'h1A, 8'h4D);
      step(1'b1, 1'b1, 3'b100, 8'h55, 8'h66, NOT);
      expect_vals(1'b1, "not", 2'b10, 2'b10, 8'h57, 8'h1A, 8'hA8);
      step(1'b1, 1'b1, 3'b100, 8'h55, 8'h66, SHL);
      expect_vals(1'b1, "shl", 2'b10, 2'b10, 8'h57, 8'h1A, 8'hAE);

      step(1'b1, 1'b1, 3'b001, 8'h55, 8'h66, NOT);
      expect_vals(1'b0, "clear_not", 2'b00, 2'b00, 8'h00, 8'h00, 8'h00);
      step(1'b1, 1'b1, 3'b010, 8'h02, 8'h04, ADD);
      expect_vals(1'b0, "load_2_4", 2'b01, 2'b01, 8'h02, 8'h04, 8'h06);

      step(1'b1, 1'b0, 3'b010, 8'h99, 8'h98, ADD);
      expect_vals(1'b0, "off1", 2'b11, 2'b11, 8'h02, 8'h04, 8'h00);
      step(1'b1, 1'b0, 3'b010, 8'h99, 8'h98, ADD);
      expect_vals(1'b0, "off2", 2'b11, 2'b11, 8'h02, 8'h04, 8'h00);
      step(1'b1, 1'b1, 3'b000, 8'h99, 8'h98, ADD);
      expect_vals(1'b1, "on_idle_pre", 2'b11, 2'b11, 8'h02, 8'h04, 8'h00);
      expect_vals(1'b0, "on_idle", 2'b11, 2'b11, 8'h02, 8'h04, 8'h00);
      step(1'b1, 1'b1, 3'b100, 8'h99, 8'h98, ADD);
      expect_vals(1'b0, "resume_hold", 2'b10, 2'b10, 8'h02, 8'h04, 8'h06);
      step(1'b1, 1'b1, 3'b011, 8'h99, 8'h98, ADD);
      expect_vals(1'b0, "multihot", 2'b10, 2'b10, 8'h02, 8'h04, 8'h06);

      step(1'b1, 1'b1, 3'b010, 8'hFF, 8'h01, ADD);
      expect_vals(1'b0, "wrap_add", 2'b01, 2'b01, 8'hFF, 8'h01, 8'h00);
      step(1'b1, 1'b1, 3'b100, 8'h00, 8'h00, SUB);
      expect_vals(1'b0, "wrap_sub", 2'b10, 2'b10, 8'hFF, 8'h01, 8'hFE);
      step(1'b1, 1'b1, 3'b100, 8'h00, 8'h00, SHL);
      expect_vals(1'b0, "wrap_shl", 2'b10, 2'b10, 8'hFF, 8'h01, 8'hFE);
      step(1'b1, 1'b1, 3'b100, 8'h00, 8'h00, 7'b0000000);
      expect_vals(1'b0, "sel_zero", 2'b10, 2'b10, 8'hFF, 8'h01, 8'h00);
      step(1'b1, 1'b1, 3'b100, 8'h00, 8'h00, 7'b1100000);
      expect_vals(1'b0, "sel_multi", 2'b10, 2'b10, 8'hFF, 8'h01, 8'h00);

      step(1'b0, 1'b1, 3'b100, 8'h00, 8'h00, ADD);
      expect_vals(1'b1, "async_rst", 2'b00, 2'b10, 8'h00, 8'h00, 8'h00);
      expect_vals(1'b0, "async_rst_held", 2'b00, 2'b10, 8'h00, 8'h00, 8'h00);
      step(1'b1, 1'b1, 3'b010, 8'h12, 8'h34, XOR);
      expect_vals(1'b0, "post_rst_load", 2'b01, 2'b01, 8'h12, 8'h34, 8'h26);

      repeat (2) @(negedge clk);
      #8;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
